mc8051_mem_seq: RTL and testbench

MC8051_MEM_SEQ -- requirements
Module: mc8051_mem_seq

---
 rtl/mc8051_mem_seq_pkg.sv | 30 +++
 rtl/mc8051_mem_seq.sv | 131 +++++++++++++
 tb/tb_mc8051_mem_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc8051_mem_seq_pkg.sv
// Shared definitions for the 8051 machine-cycle memory sequencer.
//   - tp_e       : phase encodings S1..S6 (4'd1..4'd6), also used by mc8051_mux
//   - MAX_WAIT_DEFAULT : default per-access wait budget before timeout
//   - tp_next()  : successor phase in the fixed S1->...->S6->S1 ring
package mc8051_mem_seq_pkg;

  typedef enum logic [3:0] {
    TP_S1 = 4'd1,
    TP_S2 = 4'd2,
    TP_S3 = 4'd3,
    TP_S4 = 4'd4,
    TP_S5 = 4'd5,
    TP_S6 = 4'd6
  } tp_e;

  localparam int MAX_WAIT_DEFAULT = 15;

  // Any unexpected encoding falls back to S1 so the ring always recovers.
  function automatic tp_e tp_next(input tp_e cur);
    case (cur)
      TP_S1:   tp_next = TP_S2;
      TP_S2:   tp_next = TP_S3;
      TP_S3:   tp_next = TP_S4;
      TP_S4:   tp_next = TP_S5;
      TP_S5:   tp_next = TP_S6;
      default: tp_next = TP_S1;
    endcase
  endfunction

endpackage

// File: rtl/mc8051_mem_seq.sv
// 8051 machine-cycle memory sequencer.
// Steps through phases S1..S6 and drives the shared memory port:
//   S1 opcode fetch at i_pc, S2/S3 optional operand reads, S5 optional write,
//   S4/S6 idle. A phase with an access waits for i_mem_ready; after MAX_WAIT
//   unanswered cycles it times out (reads capture 8'hFF, writes are dropped)
//   and raises the sticky o_mem_err.
// Ports:
//   i_mcu_clk, i_mcu_rst_n (sync, active-low), i_hold (freeze)
//   i_pc, i_s2/s3/s5_mem_addr_d, i_mem_wdata, i_s2_rd_en, i_s3_rd_en, i_s5_wr_en
//   i_mem_rdata, i_mem_ready           : memory response
//   o_mem_addr/wdata/rd/wr             : memory request
//   o_t_p_q / o_t_p_d                  : current / next phase
//   o_s1_instr_buffer, o_s2_data_buffer, o_s3_data_buffer : captured read data
//   o_instr_end                        : high in the S6 cycle that returns to S1
//   o_mem_err                          : sticky timeout flag
module mc8051_mem_seq
  import mc8051_mem_seq_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        i_mcu_clk,
  input  logic        i_mcu_rst_n,
  input  logic        i_hold,
  input  logic [15:0] i_pc,
  input  logic [15:0] i_s2_mem_addr_d,
  input  logic [15:0] i_s3_mem_addr_d,
  input  logic [15:0] i_s5_mem_addr_d,
  input  logic [7:0]  i_mem_wdata,
  input  logic        i_s2_rd_en,
  input  logic        i_s3_rd_en,
  input  logic        i_s5_wr_en,
  input  logic [7:0]  i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [3:0]  o_t_p_q,
  output logic [3:0]  o_t_p_d,
  output logic [7:0]  o_s1_instr_buffer,
  output logic [7:0]  o_s2_data_buffer,
  output logic [7:0]  o_s3_data_buffer,
  output logic        o_instr_end,
  output logic        o_mem_err
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  // Timeout fires on the cycle whose increment would reach MAX_WAIT, so a
  // silent access keeps its strobe up for exactly MAX_WAIT cycles.
  localparam logic [CW-1:0] WAIT_LAST = CW'((MAX_WAIT < 1) ? 0 : MAX_WAIT - 1);

  tp_e           t_p_q;
  tp_e           t_p_d;
  logic [CW-1:0] wait_cnt;
  logic          req_rd;
  logic          req_wr;
  logic          req;
  logic [15:0]   req_addr;
  logic          timeout;
  logic          advance;
  logic [7:0]    rd_capture;

  // Request decode from the registered phase and the decoder enables.
  always_comb begin
    req_rd   = 1'b0;
    req_wr   = 1'b0;
    req_addr = 16'h0000;
    case (t_p_q)
      TP_S1: begin
        req_rd   = 1'b1;
        req_addr = i_pc;
      end
      TP_S2: begin
        req_rd   = i_s2_rd_en;
        req_addr = i_s2_mem_addr_d;
      end
      TP_S3: begin
        req_rd   = i_s3_rd_en;
        req_addr = i_s3_mem_addr_d;
      end
      TP_S5: begin
        req_wr   = i_s5_wr_en;
        req_addr = i_s5_mem_addr_d;
      end
      default: ;
    endcase
  end

  assign req        = req_rd | req_wr;
  assign timeout    = req & ~i_mem_ready & (wait_cnt == WAIT_LAST);
  // Hold blocks advance, so a ready seen during hold is simply ignored.
  assign advance    = ~i_hold & (~req | i_mem_ready | timeout);
  assign t_p_d      = advance ? tp_next(t_p_q) : t_p_q;
  assign rd_capture = i_mem_ready ? i_mem_rdata : 8'hFF;

  // Strobes are masked while reset is held so nothing reaches memory.
  assign o_mem_rd    = i_mcu_rst_n & req_rd;
  assign o_mem_wr    = i_mcu_rst_n & req_wr;
  assign o_mem_addr  = (o_mem_rd | o_mem_wr) ? req_addr : 16'h0000;
  assign o_mem_wdata = o_mem_wr ? i_mem_wdata : 8'h00;
  assign o_t_p_q     = t_p_q;
  assign o_t_p_d     = t_p_d;
  assign o_instr_end = i_mcu_rst_n & advance & (t_p_q == TP_S6);

  always_ff @(posedge i_mcu_clk) begin
    if (!i_mcu_rst_n) begin
      t_p_q             <= TP_S1;
      wait_cnt          <= '0;
      o_s1_instr_buffer <= 8'h00;
      o_s2_data_buffer  <= 8'h00;
      o_s3_data_buffer  <= 8'h00;
      o_mem_err         <= 1'b0;
    end else if (advance) begin
      t_p_q    <= t_p_d;
      wait_cnt <= '0;
      if (req_rd) begin
        case (t_p_q)
          TP_S1:   o_s1_instr_buffer <= rd_capture;
          TP_S2:   o_s2_data_buffer  <= rd_capture;
          TP_S3:   o_s3_data_buffer  <= rd_capture;
          default: ;
        endcase
      end
      if (timeout) o_mem_err <= 1'b1;
    end else if (!i_hold) begin
      // Not holding and not advancing means a request is waiting on memory.
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc8051_mem_seq.sv
// Directed bench for mc8051_mem_seq with hand-computed expectations.
// Memory read data is addr[7:0] + 8'h11 unless an override value is selected.
module tb_mc8051_mem_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic [15:0] pc;
  logic [15:0] s2_addr, s3_addr, s5_addr;
  logic [7:0]  wdata;
  logic        s2_rd_en, s3_rd_en, s5_wr_en;
  logic [7:0]  rdata;
  logic        ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_wr;
  logic [3:0]  t_p_q, t_p_d;
  logic [7:0]  instr_buf, s2_buf, s3_buf;
  logic        instr_end, mem_err;

  logic        use_ovr;
  logic [7:0]  ovr_val;
  logic        overlap_seen;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_comb rdata = use_ovr ? ovr_val : (mem_addr[7:0] + 8'h11);

  mc8051_mem_seq #(.MAX_WAIT(15)) dut (
    .i_mcu_clk        (clk),
    .i_mcu_rst_n      (rst_n),
    .i_hold           (hold),
    .i_pc             (pc),
    .i_s2_mem_addr_d  (s2_addr),
    .i_s3_mem_addr_d  (s3_addr),
    .i_s5_mem_addr_d  (s5_addr),
    .i_mem_wdata      (wdata),
    .i_s2_rd_en       (s2_rd_en),
    .i_s3_rd_en       (s3_rd_en),
    .i_s5_wr_en       (s5_wr_en),
    .i_mem_rdata      (rdata),
    .i_mem_ready      (ready),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .o_mem_rd         (mem_rd),
    .o_mem_wr         (mem_wr),
    .o_t_p_q          (t_p_q),
    .o_t_p_d          (t_p_d),
    .o_s1_instr_buffer(instr_buf),
    .o_s2_data_buffer (s2_buf),
    .o_s3_data_buffer (s3_buf),
    .o_instr_end      (instr_end),
    .o_mem_err        (mem_err)
  );

  initial overlap_seen = 1'b0;
  always @(negedge clk) if (mem_rd && mem_wr) overlap_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_q;
    rst_n = 1'b0; hold = 1'b0; pc = 16'h0000;
    s2_addr = 16'h0; s3_addr = 16'h0; s5_addr = 16'h0; wdata = 8'h00;
    s2_rd_en = 1'b0; s3_rd_en = 1'b0; s5_wr_en = 1'b0;
    ready = 1'b0; use_ovr = 1'b0; ovr_val = 8'h00;

    // Reset state
    tick(); tick();
    chk("rst_q", 32'(t_p_q), 1);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_wr", 32'(mem_wr), 0);
    chk("rst_ibuf", 32'(instr_buf), 0);
    chk("rst_s2", 32'(s2_buf), 0);
    chk("rst_s3", 32'(s3_buf), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_iend", 32'(instr_end), 0);

    // Zero-wait instruction, all enables on
    pc = 16'h0100; s2_addr = 16'h0010; s3_addr = 16'h0020; s5_addr = 16'h0040;
    wdata = 8'h77; s2_rd_en = 1'b1; s3_rd_en = 1'b1; s5_wr_en = 1'b1; ready = 1'b1;
    rst_n = 1'b1;
    #1;
    for (int i = 1; i <= 6; i++) begin
      chk("zw_q", 32'(t_p_q), 32'(i));
      chk("zw_iend", 32'(instr_end), 32'(i == 6));
      chk("zw_d", 32'(t_p_d), 32'((i == 6) ? 1 : i + 1));
      case (i)
        1: begin chk("zw_s1_rd", 32'(mem_rd), 1); chk("zw_s1_addr", 32'(mem_addr), 32'h0100); end
        4: begin chk("zw_s4_rd", 32'(mem_rd), 0); chk("zw_s4_addr", 32'(mem_addr), 0); end
        5: begin
          chk("zw_s5_wr", 32'(mem_wr), 1); chk("zw_s5_rd", 32'(mem_rd), 0);
          chk("zw_s5_addr", 32'(mem_addr), 32'h0040); chk("zw_s5_wd", 32'(mem_wdata), 32'h77);
        end
        6: chk("zw_s6_wd", 32'(mem_wdata), 0);
        default: ;
      endcase
      tick();
    end
    chk("zw_end_q", 32'(t_p_q), 1);
    chk("zw_ibuf", 32'(instr_buf), 32'h11);
    chk("zw_s2", 32'(s2_buf), 32'h21);
    chk("zw_s3", 32'(s3_buf), 32'h31);

    // S2 read with three wait cycles
    s2_addr = 16'h0030;
    tick();
    ready = 1'b0; use_ovr = 1'b1; ovr_val = 8'h5A;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("w3_q", 32'(t_p_q), 2);
      chk("w3_d", 32'(t_p_d), 2);
      chk("w3_addr", 32'(mem_addr), 32'h0030);
      chk("w3_rd", 32'(mem_rd), 1);
      tick();
    end
    ready = 1'b1;
    #1;
    chk("w3_addr4", 32'(mem_addr), 32'h0030);
    chk("w3_d_adv", 32'(t_p_d), 3);
    tick();
    use_ovr = 1'b0;
    chk("w3_q_s3", 32'(t_p_q), 3);
    chk("w3_s2buf", 32'(s2_buf), 32'h5A);

    // Hold in S3 with ready high
    s3_addr = 16'h0050; hold = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_q", 32'(t_p_q), 3);
      chk("hold_d", 32'(t_p_d), 3);
      chk("hold_rd", 32'(mem_rd), 1);
      chk("hold_s3", 32'(s3_buf), 32'h31);
      tick();
    end
    hold = 1'b0;
    #1;
    chk("hold_rel_d", 32'(t_p_d), 4);
    tick();
    chk("hold_rel_q", 32'(t_p_q), 4);
    chk("hold_s3_cap", 32'(s3_buf), 32'h61);

    // S5 write never acknowledged: timeout
    tick();
    ready = 1'b0;
    #1;
    n = 0;
    while (t_p_q == 4'd5 && n < 40) begin
      if (mem_wr) n++;
      tick();
    end
    chk("to_wr_cycles", 32'(n), 15);
    chk("to_q", 32'(t_p_q), 6);
    chk("to_err", 32'(mem_err), 1);
    chk("to_s6_wr", 32'(mem_wr), 0);
    ready = 1'b1;
    tick();
    chk("to_err_sticky", 32'(mem_err), 1);

    // S1 fetch never acknowledged: buffer gets 8'hFF
    ready = 1'b0;
    #1;
    n = 0;
    while (t_p_q == 4'd1 && n < 40) begin
      n++;
      tick();
    end
    chk("tof_cycles", 32'(n), 15);
    chk("tof_ibuf", 32'(instr_buf), 32'hFF);
    chk("tof_q", 32'(t_p_q), 2);

    // Reset mid-wait in S2
    tick(); tick();
    chk("mr_pre_q", 32'(t_p_q), 2);
    rst_n = 1'b0; pc = 16'h0203;
    #1;
    chk("mr_rd_during", 32'(mem_rd), 0);
    tick();
    chk("mr_q", 32'(t_p_q), 1);
    chk("mr_ibuf", 32'(instr_buf), 0);
    chk("mr_s2", 32'(s2_buf), 0);
    chk("mr_s3", 32'(s3_buf), 0);
    chk("mr_err", 32'(mem_err), 0);
    chk("mr_rd", 32'(mem_rd), 0);
    chk("mr_wr", 32'(mem_wr), 0);
    rst_n = 1'b1; ready = 1'b1;
    s2_rd_en = 1'b0; s3_rd_en = 1'b0; s5_wr_en = 1'b0;
    #1;
    chk("mr_fetch_rd", 32'(mem_rd), 1);
    chk("mr_fetch_addr", 32'(mem_addr), 32'h0203);
    tick();
    chk("mr_ibuf_new", 32'(instr_buf), 32'h14);
    chk("mr_q2", 32'(t_p_q), 2);

    // All enables off: only S1 accesses, one cycle per phase
    exp_q = 2;
    for (int i = 0; i < 12; i++) begin
      chk("en0_q", 32'(t_p_q), 32'(exp_q));
      chk("en0_rd", 32'(mem_rd), 32'(exp_q == 1));
      chk("en0_wr", 32'(mem_wr), 0);
      tick();
      exp_q = (exp_q == 6) ? 1 : exp_q + 1;
    end

    chk("no_overlap", 32'(overlap_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
